a2d_rr_intf: RTL

- Producer side of the load-cell/sensor path. Round-robin reads an external 8-channel, 12-bit SPI A2D.
- Publishes registered lft_ld and rght_ld (consumed by the steering-enable logic), plus steer_pot and batt.
- Contains its own SPI monarch: 16-bit frames, SCLK = clk/32.
- Sits between the A2D pins and the balance/steer control blocks.

---
 rtl/a2d_rr_intf_if.sv | 24 ++
 rtl/a2d_rr_intf.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/a2d_rr_intf_if.sv
// Handshake and pin bundle for the round-robin A2D reader.
// The slave modport is the reader itself; the master modport is the A2D pins plus the nxt source.
interface a2d_rr_intf_if;
    logic        nxt;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic [11:0] steer_pot;
    logic [11:0] batt;
    logic        cnv_cmplt;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;

    modport slave (
        input  nxt, MISO,
        output lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, SS_n, SCLK, MOSI
    );

    modport master (
        output nxt, MISO,
        input  lft_ld, rght_ld, steer_pot, batt, cnv_cmplt, SS_n, SCLK, MOSI
    );
endinterface

// File: rtl/a2d_rr_intf.sv
// Round-robin reader for an 8-ch 12-bit SPI A2D with a built-in 16-bit SPI monarch (SCLK = clk/32).
// Optional macro LD_FILT_EN: IIR-smooth the left/right load-cell results.
module a2d_rr_intf #(
    parameter logic [2:0] LFT_CH   = 3'd0,
    parameter logic [2:0] RGHT_CH  = 3'd4,
    parameter logic [2:0] STEER_CH = 3'd5,
    parameter logic [2:0] BATT_CH  = 3'd6
) (
    input  logic          clk,
    input  logic          rst_n,
    a2d_rr_intf_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CNV  = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_READ = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_idx;
    logic        r_start;
    logic        r_cnv_cmplt;
    logic [11:0] r_lft, r_rght, r_steer, r_batt;

    logic        r_ss_n;
    logic [4:0]  r_div;
    logic [15:0] r_shft;
    logic        r_first;
    logic        r_bp;
    logic [3:0]  r_bitcnt;
    logic        r_miso;

    logic [2:0]  w_ch;
    logic [15:0] w_cmd;
    logic        w_smpl;
    logic        w_fall;
    logic        w_frame_done;
    logic [11:0] w_rdata;
    logic        w_latch;
    logic [11:0] w_lft_new, w_rght_new;

    always_comb begin
        w_ch = LFT_CH;
        case (r_idx)
            2'd0: w_ch = LFT_CH;
            2'd1: w_ch = RGHT_CH;
            2'd2: w_ch = STEER_CH;
            2'd3: w_ch = BATT_CH;
            default: w_ch = LFT_CH;
        endcase
    end

    assign w_cmd = {2'b00, w_ch, 11'h000};

    // Sampling/shifting stop once the 16th bit is in; the rest of the frame is back porch.
    assign w_smpl       = !r_ss_n && !r_bp && (r_div == 5'b01111);
    assign w_fall       = !r_ss_n && !r_bp && (r_div == 5'b11111);
    assign w_frame_done = !r_ss_n &&  r_bp && (r_div == 5'b11110);

    // Last bit is never shifted in; it is still sitting in the MISO sample flop.
    assign w_rdata = {r_shft[10:0], r_miso};
    assign w_latch = (r_state == ST_READ) && w_frame_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ss_n   <= 1'b1;
            r_div    <= 5'b10111;
            r_shft   <= 16'h0000;
            r_first  <= 1'b0;
            r_bp     <= 1'b0;
            r_bitcnt <= 4'd0;
            r_miso   <= 1'b0;
        end else if (r_start) begin
            r_ss_n   <= 1'b0;
            r_div    <= 5'b10111;
            r_shft   <= w_cmd;
            r_first  <= 1'b1;
            r_bp     <= 1'b0;
            r_bitcnt <= 4'd0;
        end else if (!r_ss_n) begin
            r_div <= r_div + 5'd1;
            if (w_smpl) begin
                r_miso   <= bus.MISO;
                r_bitcnt <= r_bitcnt + 4'd1;
                if (r_bitcnt == 4'd15)
                    r_bp <= 1'b1;
            end
            if (w_fall) begin
                r_first <= 1'b0;
                if (!r_first)
                    r_shft <= {r_shft[14:0], r_miso};
            end
            if (w_frame_done)
                r_ss_n <= 1'b1;
        end
    end

`ifdef LD_FILT_EN
    logic        r_lft_vld, r_rght_vld;
    logic [13:0] w_lft_sum, w_rght_sum;

    assign w_lft_sum  = {2'b00, r_lft}  * 14'd3 + {2'b00, w_rdata};
    assign w_rght_sum = {2'b00, r_rght} * 14'd3 + {2'b00, w_rdata};
    // First update after reset seeds the filter with the raw sample.
    assign w_lft_new  = r_lft_vld  ? 12'(w_lft_sum  >> 2) : w_rdata;
    assign w_rght_new = r_rght_vld ? 12'(w_rght_sum >> 2) : w_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lft_vld  <= 1'b0;
            r_rght_vld <= 1'b0;
        end else if (w_latch) begin
            if (r_idx == 2'd0) r_lft_vld  <= 1'b1;
            if (r_idx == 2'd1) r_rght_vld <= 1'b1;
        end
    end
`else
    assign w_lft_new  = w_rdata;
    assign w_rght_new = w_rdata;
`endif

    // Frame starts are issued one clk after the decision, which yields the 1-clk
    // front delay after nxt and the 1-clk SS_n-high gap between the two frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= 2'd0;
            r_start     <= 1'b0;
            r_cnv_cmplt <= 1'b0;
            r_lft       <= 12'h000;
            r_rght      <= 12'h000;
            r_steer     <= 12'h000;
            r_batt      <= 12'h000;
        end else begin
            r_start     <= 1'b0;
            r_cnv_cmplt <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.nxt) begin
                        r_state <= ST_CNV;
                        r_start <= 1'b1;
                    end
                end
                ST_CNV: begin
                    if (w_frame_done) begin
                        r_state <= ST_GAP;
                        r_start <= 1'b1;
                    end
                end
                ST_GAP: r_state <= ST_READ;
                ST_READ: begin
                    if (w_frame_done) begin
                        case (r_idx)
                            2'd0: r_lft   <= w_lft_new;
                            2'd1: r_rght  <= w_rght_new;
                            2'd2: r_steer <= w_rdata;
                            2'd3: r_batt  <= w_rdata;
                            default: ;
                        endcase
                        r_cnv_cmplt <= 1'b1;
                        r_idx       <= r_idx + 2'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.lft_ld    = r_lft;
    assign bus.rght_ld   = r_rght;
    assign bus.steer_pot = r_steer;
    assign bus.batt      = r_batt;
    assign bus.cnv_cmplt = r_cnv_cmplt;
    assign bus.SS_n      = r_ss_n;
    assign bus.SCLK      = r_div[4] | r_ss_n;
    assign bus.MOSI      = r_shft[15];

endmodule
